pwm_duty_decoder: RTL

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

---
 rtl/pwm_duty_decoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// Recovers the dithered duty word of a half-bridge gate pair by counting high
// cycles over FRAMES windows of PERIOD clocks; also measures both deadtimes and flags overlap.
module pwm_duty_decoder #(
    parameter int PERIOD = 128,
    parameter int FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       duty_high,
    input  logic       duty_low,
    output logic [9:0] duty_out,
    output logic       duty_valid,
    output logic [5:0] dt_hl,
    output logic [5:0] dt_lh,
    output logic       overlap_err,
    output logic       locked
);

    localparam logic [6:0] WIN_LAST   = 7'(PERIOD - 1);
    localparam logic [2:0] FRAME_LAST = 3'(FRAMES - 1);
    localparam logic [5:0] DT_MAX     = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Channel 0 is duty_high, channel 1 is duty_low throughout.
    logic [1:0] w_async_in;
    logic [1:0] w_sync;
    logic [1:0] w_prev;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_async_in = {duty_low, duty_high};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic r_s1;
            logic r_s2;
            logic r_d;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                    r_d  <= 1'b0;
                end else begin
                    r_s1 <= w_async_in[gi];
                    r_s2 <= r_s1;
                    r_d  <= r_s2;
                end
            end

            assign w_sync[gi] = r_s2;
            assign w_prev[gi] = r_d;
            assign w_rise[gi] = r_s2 & ~r_d;
            assign w_fall[gi] = ~r_s2 & r_d;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!en) begin
                    w_state_next = ST_IDLE;
                end else if (w_rise[0]) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign locked = (r_state == ST_RUN);

    // The locking edge itself is window cycle 0, so it is processed while still in ARM.
    logic        w_run_cycle;
    logic        w_win_end;
    logic        w_frame_end;
    logic [7:0]  w_hi_cnt_inc;
    logic [11:0] w_acc_sum;
    logic [9:0]  w_duty_sat;

    logic [6:0]  r_win_cnt;
    logic [7:0]  r_hi_cnt;
    logic [10:0] r_acc;
    logic [2:0]  r_frame_cnt;
    logic [9:0]  r_duty_out;
    logic        r_duty_valid;

    assign w_run_cycle  = en && ((r_state == ST_RUN) || ((r_state == ST_ARM) && w_rise[0]));
    assign w_win_end    = w_run_cycle && (r_win_cnt == WIN_LAST);
    assign w_frame_end  = w_win_end && (r_frame_cnt == FRAME_LAST);
    assign w_hi_cnt_inc = r_hi_cnt + 8'(w_sync[0]);
    assign w_acc_sum    = {1'b0, r_acc} + {4'b0, w_hi_cnt_inc};
    assign w_duty_sat   = (w_acc_sum > 12'd1023) ? 10'h3FF : w_acc_sum[9:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_acc        <= '0;
            r_frame_cnt  <= '0;
            r_duty_out   <= '0;
            r_duty_valid <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            if (!w_run_cycle) begin
                // Partial window and frame data is dropped; duty_out keeps its last value.
                r_win_cnt   <= '0;
                r_hi_cnt    <= '0;
                r_acc       <= '0;
                r_frame_cnt <= '0;
            end else if (w_win_end) begin
                r_win_cnt <= '0;
                r_hi_cnt  <= '0;
                if (w_frame_end) begin
                    r_frame_cnt  <= '0;
                    r_acc        <= '0;
                    r_duty_out   <= w_duty_sat;
                    r_duty_valid <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 3'd1;
                    r_acc       <= w_acc_sum[10:0];
                end
            end else begin
                r_win_cnt <= r_win_cnt + 7'd1;
                r_hi_cnt  <= w_hi_cnt_inc;
            end
        end
    end

    assign duty_out   = r_duty_out;
    assign duty_valid = r_duty_valid;

    // Channel gi times from its own fall to the other channel's rise.
    logic             w_dt_en;
    logic [1:0][5:0]  w_dt_val;

    assign w_dt_en = (r_state != ST_IDLE);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_dt
            localparam int OTHER = 1 - gi;
            logic       r_active;
            logic [5:0] r_cnt;
            logic [5:0] r_dt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                    r_dt     <= '0;
                end else if (!w_dt_en) begin
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                end else if (w_fall[gi]) begin
                    if (w_rise[OTHER]) begin
                        r_dt     <= '0;
                        r_active <= 1'b0;
                    end else if (!w_sync[OTHER]) begin
                        r_active <= 1'b1;
                        r_cnt    <= 6'd1;
                    end else begin
                        r_active <= 1'b0;
                    end
                end else if (r_active) begin
                    if (w_rise[OTHER] && !w_sync[gi]) begin
                        r_dt     <= r_cnt;
                        r_active <= 1'b0;
                    end else if (w_sync[gi] || w_sync[OTHER]) begin
                        r_active <= 1'b0;
                    end else if (r_cnt != DT_MAX) begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
            end

            assign w_dt_val[gi] = r_dt;
        end
    endgenerate

    assign dt_hl = w_dt_val[0];
    assign dt_lh = w_dt_val[1];

    logic r_overlap;

    // Set takes priority over clear so a coincident overlap is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overlap <= 1'b0;
        end else if (w_sync[0] && w_sync[1]) begin
            r_overlap <= 1'b1;
        end else if (clr) begin
            r_overlap <= 1'b0;
        end
    end

    assign overlap_err = r_overlap;

endmodule
